// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MEM-stage data-memory access unit.
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ALIGN   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  // Illegal size counts as misaligned so both share one error path.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    bad = 1'b1;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = off[0];
      SZ_WORD: bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-enable generation, store lane replication and load extraction for a
// big-endian word (offset 0 = bits 31:24).
module lsu_lane_align
  import mips_mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [31:0] shifted;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    // Bring the addressed byte down to bits 7:0: shift by (3 - offset) * 8.
    shifted   = rdata >> {~offset, 3'b000};
    byte_v    = shifted[7:0];
    half_v    = offset[1] ? rdata[15:0] : rdata[31:16];
    be        = 4'b0000;
    wdata_rep = 32'h0;
    rdata_ext = 32'h0;
    case (size)
      SZ_BYTE: begin
        be        = 4'b1000 >> offset;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{~is_unsigned & byte_v[7]}}, byte_v};
      end
      SZ_HALF: begin
        be        = offset[1] ? 4'b0011 : 4'b1100;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{16{~is_unsigned & half_v[15]}}, half_v};
      end
      SZ_WORD: begin
        be        = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator: turns pipeline load/store requests into byte-enabled
// word transactions with a bounded wait for mem_ack.
module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_valid,
  output logic              cpu_ready,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_size,
  input  logic              cpu_unsigned,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_rvalid,
  output logic [31:0]       cpu_rdata,
  output logic [1:0]        cpu_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic              ready_q, ready_d;
  logic              rvalid_q, rvalid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        err_q, err_d;
  logic              req_q, req_d;
  logic              mwe_q, mwe_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       mwdata_q, mwdata_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              rq_we_q, rq_we_d;
  logic [1:0]        rq_size_q, rq_size_d;
  logic              rq_uns_q, rq_uns_d;
  logic [1:0]        rq_off_q, rq_off_d;

  logic              accept;
  logic [1:0]        al_size, al_off;
  logic              al_uns;
  logic [3:0]        al_be;
  logic [31:0]       al_wdata, al_rdata;

  assign accept = cpu_valid & ready_q;

  // In IDLE the aligner sees the incoming request, otherwise the latched one.
  assign al_size = (state_q == IDLE) ? cpu_size : rq_size_q;
  assign al_off  = (state_q == IDLE) ? cpu_addr[1:0] : rq_off_q;
  assign al_uns  = (state_q == IDLE) ? cpu_unsigned : rq_uns_q;

  lsu_lane_align u_align (
    .size       (al_size),
    .offset     (al_off),
    .is_unsigned(al_uns),
    .wdata      (cpu_wdata),
    .rdata      (mem_rdata),
    .be         (al_be),
    .wdata_rep  (al_wdata),
    .rdata_ext  (al_rdata)
  );

  always_comb begin
    state_d   = state_q;
    rvalid_d  = 1'b0;
    rdata_d   = rdata_q;
    err_d     = err_q;
    req_d     = req_q;
    mwe_d     = mwe_q;
    maddr_d   = maddr_q;
    be_d      = be_q;
    mwdata_d  = mwdata_q;
    cnt_d     = cnt_q;
    rq_we_d   = rq_we_q;
    rq_size_d = rq_size_q;
    rq_uns_d  = rq_uns_q;
    rq_off_d  = rq_off_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          rq_we_d   = cpu_we;
          rq_size_d = cpu_size;
          rq_uns_d  = cpu_unsigned;
          rq_off_d  = cpu_addr[1:0];
          if (is_misaligned(cpu_size, cpu_addr[1:0])) begin
            state_d  = RESP;
            rvalid_d = 1'b1;
            err_d    = ERR_ALIGN;
            rdata_d  = 32'h0;
          end else begin
            state_d  = BUSY;
            req_d    = 1'b1;
            mwe_d    = cpu_we;
            maddr_d  = {cpu_addr[ADDR_W-1:2], 2'b00};
            be_d     = al_be;
            mwdata_d = al_wdata;
            cnt_d    = 8'h0;
          end
        end
      end
      BUSY: begin
        if (mem_ack) begin
          state_d  = RESP;
          req_d    = 1'b0;
          mwe_d    = 1'b0;
          rvalid_d = 1'b1;
          err_d    = ERR_OK;
          rdata_d  = rq_we_q ? 32'h0 : al_rdata;
        end else if (cnt_q == CntLast) begin
          state_d  = RESP;
          req_d    = 1'b0;
          mwe_d    = 1'b0;
          rvalid_d = 1'b1;
          err_d    = ERR_TIMEOUT;
          rdata_d  = 32'h0;
        end else begin
          cnt_d = cnt_q + 8'h1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      ready_q   <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'h0;
      err_q     <= ERR_OK;
      req_q     <= 1'b0;
      mwe_q     <= 1'b0;
      maddr_q   <= '0;
      be_q      <= 4'h0;
      mwdata_q  <= 32'h0;
      cnt_q     <= 8'h0;
      rq_we_q   <= 1'b0;
      rq_size_q <= SZ_BYTE;
      rq_uns_q  <= 1'b0;
      rq_off_q  <= 2'b00;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      req_q     <= req_d;
      mwe_q     <= mwe_d;
      maddr_q   <= maddr_d;
      be_q      <= be_d;
      mwdata_q  <= mwdata_d;
      cnt_q     <= cnt_d;
      rq_we_q   <= rq_we_d;
      rq_size_q <= rq_size_d;
      rq_uns_q  <= rq_uns_d;
      rq_off_q  <= rq_off_d;
    end
  end

  assign cpu_ready  = ready_q;
  assign cpu_rvalid = rvalid_q;
  assign cpu_rdata  = rdata_q;
  assign cpu_err    = err_q;
  assign mem_req    = req_q;
  assign mem_we     = mwe_q;
  assign mem_addr   = maddr_q;
  assign mem_be     = be_q;
  assign mem_wdata  = mwdata_q;

endmodule
